// File: rtl/logic_pkg.sv
// Shared definitions for the logic-op arbiter block.
//  - OP_NOT/OP_AND/OP_OR/OP_XOR : 2-bit operation codes on req_op lanes
//  - state_t                    : arbiter FSM states (ST_IDLE, ST_RESP)
package logic_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit.
// Ports:
//  i_op [1:0]       operation code (logic_pkg OP_*)
//  i_a  [DATA_W-1:0] operand A
//  i_b  [DATA_W-1:0] operand B (unused for NOT)
//  o_y  [DATA_W-1:0] result, same width as operands
module logic_unit
    import logic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        o_y = '0;
        case (i_op)
            OP_NOT:  o_y = ~i_a;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit between NUM_REQ requesters.
// One operation in flight; the result is registered and tagged with the
// index of the requester that was served.
// Ports:
//  clk, rst_n          clock, async active-low reset
//  req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//  req_op              2-bit op per requester, lane i at [2i+1:2i]
//  req_a, req_b        DATA_W operands per requester, lane i at [DATA_W*i +: DATA_W]
//  rsp_valid/rsp_ready response handshake
//  rsp_id              index of the served requester
//  rsp_data            registered result
module logic_op_arbiter
    import logic_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;

    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_found;
    logic [ID_W-1:0]     w_grant_id;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ID_W:0]       w_idx_sum;
    logic [ID_W-1:0]     w_idx;
    logic [1:0]          w_sel_op;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [DATA_W-1:0]   w_result;

    logic [1:0]          w_op_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_b_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_op_arr[gi] = req_op[2*gi +: 2];
        assign w_a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
        assign w_b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    end

    // Priority search starting at r_rr_ptr, wrapping modulo NUM_REQ. The
    // first hit wins; later hits are ignored via w_found.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx_sum  = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx_sum >= NUM_REQ_W) begin
                w_idx_sum = w_idx_sum - NUM_REQ_W;
            end
            w_idx = w_idx_sum[ID_W-1:0];
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_grant_id == LAST_ID) ? '0 : w_grant_id + ID_W'(1);

    // Only the granted lane reaches the logic unit, so undriven operands on
    // other lanes never affect the result.
    assign w_sel_op = w_op_arr[w_grant_id];
    assign w_sel_a  = w_a_arr[w_grant_id];
    assign w_sel_b  = w_b_arr[w_grant_id];

    logic_unit #(
        .DATA_W (DATA_W)
    ) u_logic_unit (
        .i_op (w_sel_op),
        .i_a  (w_sel_a),
        .i_b  (w_sel_b),
        .o_y  (w_result)
    );

    // Next-state and grant. req_ready is gated by rst_n so no requester sees
    // an accept while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && rst_n) begin
                    w_accept              = 1'b1;
                    req_ready[w_grant_id] = 1'b1;
                    w_state_nxt           = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all state and output registers use non-blocking assignments so
    // every flop samples pre-edge values, and all of them are cleared by the
    // async reset so a reset mid-response drops it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_data  <= w_result;
                r_rsp_id    <= w_grant_id;
                r_rsp_valid <= 1'b1;
                r_rr_ptr    <= w_ptr_nxt;
            end else if (r_state == ST_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule
